// File: rtl/otter_btn_pkg.sv
// ----------------------------------------------------------------------------
// otter_btn_pkg
// Shared definitions for the button interrupt controller:
//   state_t           - controller FSM states
//   HOLDOFF_CLKS_DEF  - default number of INTR-low clocks after an acknowledge
//   SRC_ID_W          - width of the serviced-source index
//   MAX_SRC           - largest supported number of sources
//   lowest_idx()      - index of the lowest set bit (priority pick)
//   popcount8()       - number of set bits in an 8-bit vector
// ----------------------------------------------------------------------------
package otter_btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

    localparam int HOLDOFF_CLKS_DEF = 8;
    localparam int SRC_ID_W         = 3;
    localparam int MAX_SRC          = 8;

    // Lowest index wins, so scan from the top and let lower bits overwrite.
    function automatic logic [SRC_ID_W-1:0] lowest_idx(input logic [MAX_SRC-1:0] v);
        logic [SRC_ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SRC_ID_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/btn_intr_ctrl_rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
// Registers a vector once and flags bits that are high now but were low on
// the previous clock, so a multi-clock pulse produces a single event.
//   CLK   in   clock
//   RST   in   synchronous active-high reset (clears the history register)
//   SIG   in   [W]  input vector
//   RISE  out  [W]  combinational rising-edge flags (SIG & ~previous SIG)
// ----------------------------------------------------------------------------
module rise_detect #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] SIG,
    output logic [W-1:0] RISE
);

    logic [W-1:0] prev_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= SIG;
        end
    end

    // Gated by reset so that nothing seen while RST is high becomes an event.
    assign RISE = RST ? '0 : (SIG & ~prev_reg);

endmodule

// File: rtl/btn_intr_ctrl.sv
// ----------------------------------------------------------------------------
// btn_intr_ctrl
// Interrupt controller for debounced button one-shots feeding the OTTER CPU.
// Events are latched as PENDING, serviced lowest-index first through a
// request / acknowledge / holdoff handshake.
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   BTN_PULSE  in   [N_SRC] debouncer one-shot outputs
//   EN_MASK    in   [N_SRC] per-source interrupt enable
//   INTR_ACK   in   CPU acknowledge pulse (honoured only while requesting)
//   OVF_CLR    in   pulse clearing all OVERFLOW bits
//   INTR       out  registered interrupt request
//   SRC_ID     out  [3] index of the source being serviced
//   PENDING    out  [N_SRC] latched, unserviced events
//   OVERFLOW   out  [N_SRC] sticky "event while already pending" flags
//   EVT_CNT    out  [8] accepted events, modulo 256
// ----------------------------------------------------------------------------
module btn_intr_ctrl
    import otter_btn_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int HOLDOFF_CLKS = HOLDOFF_CLKS_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_SRC-1:0]    BTN_PULSE,
    input  logic [N_SRC-1:0]    EN_MASK,
    input  logic                INTR_ACK,
    input  logic                OVF_CLR,
    output logic                INTR,
    output logic [SRC_ID_W-1:0] SRC_ID,
    output logic [N_SRC-1:0]    PENDING,
    output logic [N_SRC-1:0]    OVERFLOW,
    output logic [7:0]          EVT_CNT
);

    state_t              state_reg, state_next;
    logic                intr_reg;
    logic [SRC_ID_W-1:0] src_reg, src_next;
    logic [N_SRC-1:0]    pend_reg, pend_next;
    logic [N_SRC-1:0]    ovf_reg, ovf_next;
    logic [7:0]          evt_reg, evt_next;
    logic [7:0]          hold_cnt_reg, hold_cnt_next;

    logic [N_SRC-1:0]    edge_vec;
    logic [N_SRC-1:0]    clr_vec;
    logic [N_SRC-1:0]    req_vec;
    logic [7:0]          edge_ext;
    logic [7:0]          req_ext;
    logic [7:0]          mask_ext;
    logic                ack_fire;
    logic                src_en;
    logic                hold_done;

    rise_detect #(
        .W (N_SRC)
    ) u_rise (
        .CLK  (CLK),
        .RST  (RST),
        .SIG  (BTN_PULSE),
        .RISE (edge_vec)
    );

    assign edge_ext = 8'(edge_vec);
    assign mask_ext = 8'(EN_MASK);
    assign req_vec  = pend_reg & EN_MASK;
    assign req_ext  = 8'(req_vec);
    assign ack_fire = (state_reg == ST_REQ) && INTR_ACK;
    assign src_en   = mask_ext[src_reg];

    // Holdoff lasts HOLDOFF_CLKS-1 clocks; the idle re-arbitration clock that
    // follows completes exactly HOLDOFF_CLKS INTR-low clocks after the ack.
    // Leaving when the count reaches HOLDOFF_CLKS-1 means cnt+1 >= N-1.
    assign hold_done = ({1'b0, hold_cnt_reg} + 9'd2) >= 9'(HOLDOFF_CLKS);

    // Per-source pending / overflow. A fresh edge always (re)sets pending,
    // so an edge coinciding with its own ack-clear keeps the bit set and
    // is not an overflow. A new overflow beats a coincident OVF_CLR.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign clr_vec[gi]   = ack_fire && (src_reg == SRC_ID_W'(gi));
            assign pend_next[gi] = (pend_reg[gi] & ~clr_vec[gi]) | edge_vec[gi];
            assign ovf_next[gi]  = (ovf_reg[gi] & ~OVF_CLR)
                                 | (edge_vec[gi] & pend_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    assign evt_next = evt_reg + 8'(popcount8(edge_ext));

    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_next = ST_REQ;
                    src_next   = lowest_idx(req_ext);
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a mask drop in the same clock.
                if (INTR_ACK) begin
                    state_next    = ST_HOLDOFF;
                    hold_cnt_next = '0;
                end else if (!src_en) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                hold_cnt_next = hold_cnt_reg + 8'd1;
                if (hold_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            intr_reg     <= 1'b0;
            src_reg      <= '0;
            pend_reg     <= '0;
            ovf_reg      <= '0;
            evt_reg      <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            intr_reg     <= (state_next == ST_REQ);
            src_reg      <= src_next;
            pend_reg     <= pend_next;
            ovf_reg      <= ovf_next;
            evt_reg      <= evt_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign INTR     = intr_reg;
    assign SRC_ID   = src_reg;
    assign PENDING  = pend_reg;
    assign OVERFLOW = ovf_reg;
    assign EVT_CNT  = evt_reg;

endmodule
